// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a combinational instruction ROM.
// Holds the program counter, drives the ROM word address, captures instructions into
// the IF/ID register and presents them to decode over a valid/ready handshake.
// A taken redirect flushes the IF/ID register. A redirect to a misaligned target
// parks the stage in FAULT until the next reset.
module fetch_unit #(
   parameter int              XLEN       = 32,
   parameter int              ADDR_WIDTH = 8,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]           imem_rd,
   input  logic                  redirect_valid,
   input  logic [XLEN-1:0]       redirect_pc,
   input  logic                  id_ready,
   output logic                  if_valid,
   output logic [31:0]           if_instr,
   output logic [XLEN-1:0]       if_pc,
   output logic [XLEN-1:0]       if_pc_plus4,
   output logic                  fetch_fault,
   output logic [31:0]           fetch_count
);

   typedef enum logic [1:0] {
      BOOT  = 2'b00,
      RUN   = 2'b01,
      FAULT = 2'b10
   } state_t;

   localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);

   state_t            state_r, state_s;
   logic [XLEN-1:0]   pc_r, pc_s;
   logic              if_valid_r, if_valid_s;
   logic [31:0]       if_instr_r, if_instr_s;
   logic [XLEN-1:0]   if_pc_r, if_pc_s;
   logic [XLEN-1:0]   if_pc_plus4_r, if_pc_plus4_s;
   logic              fetch_fault_r, fetch_fault_s;
   logic [31:0]       fetch_count_r, fetch_count_s;
   logic              transfer_s;
   logic              load_s;
   logic              misaligned_s;

   // Handshake qualifiers derived from the current IF/ID state and inputs.
   always_comb begin
      transfer_s   = if_valid_r && id_ready;
      load_s       = !if_valid_r || id_ready;
      misaligned_s = (redirect_pc[1:0] != 2'b00);
   end

   // Next-state and datapath update: redirect faults first, then redirect, then load, else stall.
   always_comb begin
      state_s       = state_r;
      pc_s          = pc_r;
      if_valid_s    = if_valid_r;
      if_instr_s    = if_instr_r;
      if_pc_s       = if_pc_r;
      if_pc_plus4_s = if_pc_plus4_r;
      fetch_fault_s = fetch_fault_r;
      fetch_count_s = fetch_count_r;

      case (state_r)
         BOOT: begin
            // pc holds for one cycle so the first ROM read sees RESET_PC settled
            if_valid_s = 1'b0;
            state_s    = RUN;
         end

         RUN: begin
            // a handshake completes this cycle regardless of what happens to IF/ID
            if (transfer_s) begin
               fetch_count_s = fetch_count_r + 32'd1;
            end else begin
               fetch_count_s = fetch_count_r;
            end

            if (redirect_valid && misaligned_s) begin
               state_s       = FAULT;
               if_valid_s    = 1'b0;
               fetch_fault_s = 1'b1;
            end else if (redirect_valid) begin
               // flush wins over a stall; the word at the old pc is dropped
               pc_s       = redirect_pc;
               if_valid_s = 1'b0;
            end else if (load_s) begin
               if_instr_s    = imem_rd;
               if_pc_s       = pc_r;
               if_pc_plus4_s = pc_r + PC_STEP;
               if_valid_s    = 1'b1;
               pc_s          = pc_r + PC_STEP;
            end else begin
               // stall: everything holds so decode sees a stable instruction
               pc_s       = pc_r;
               if_valid_s = if_valid_r;
            end
         end

         FAULT: begin
            // absorbing: only reset leaves this state
            if_valid_s = 1'b0;
            state_s    = FAULT;
         end

         default: begin
            // illegal encoding: park safely with nothing presented to decode
            state_s       = FAULT;
            if_valid_s    = 1'b0;
            fetch_fault_s = 1'b1;
         end
      endcase
   end

   // State and IF/ID registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= BOOT;
         pc_r          <= RESET_PC;
         if_valid_r    <= 1'b0;
         if_instr_r    <= NOP_INSTR;
         if_pc_r       <= '0;
         if_pc_plus4_r <= '0;
         fetch_fault_r <= 1'b0;
         fetch_count_r <= 32'd0;
      end else begin
         state_r       <= state_s;
         pc_r          <= pc_s;
         if_valid_r    <= if_valid_s;
         if_instr_r    <= if_instr_s;
         if_pc_r       <= if_pc_s;
         if_pc_plus4_r <= if_pc_plus4_s;
         fetch_fault_r <= fetch_fault_s;
         fetch_count_r <= fetch_count_s;
      end
   end

   // ROM address is a pure slice of pc; everything else comes straight from registers.
   always_comb begin
      imem_addr   = pc_r[ADDR_WIDTH+1:2];
      if_valid    = if_valid_r;
      if_instr    = if_instr_r;
      if_pc       = if_pc_r;
      if_pc_plus4 = if_pc_plus4_r;
      fetch_fault = fetch_fault_r;
      fetch_count = fetch_count_r;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit; ROM word k holds 32'h1000_0000 + k.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rd;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        fetch_fault;
   logic [31:0] fetch_count;

   int checks;
   int failures;

   fetch_unit #(
      .XLEN(32), .ADDR_WIDTH(8), .RESET_PC(32'h0000_0000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
      .fetch_fault(fetch_fault), .fetch_count(fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // combinational ROM model
   always_comb imem_rd = 32'h1000_0000 + {24'd0, imem_addr};

   task automatic test_reset();
      rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
      @(negedge clk); @(negedge clk);
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", if_valid); end
      checks++; if (if_instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr got=%h exp=00000013", if_instr); end
      checks++; if (if_pc !== 32'd0 || if_pc_plus4 !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h/%h exp=0/0", if_pc, if_pc_plus4); end
      checks++; if (fetch_fault !== 1'b0 || fetch_count !== 32'd0) begin failures++; $display("FAIL reset_flags got=%0b/%0d exp=0/0", fetch_fault, fetch_count); end
      checks++; if (imem_addr !== 8'd0) begin failures++; $display("FAIL reset_addr got=%h exp=00", imem_addr); end
      rst_n = 1'b1;
      // cycle 0 (BOOT) and cycle 1 show nothing valid
      for (int i = 0; i < 2; i++) begin
         if (i > 0) @(negedge clk);
         checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL boot_valid cyc=%0d got=%0b exp=0", i, if_valid); end
      end
   endtask

   task automatic test_stream();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%0b exp=1", k, if_valid); end
         checks++; if (if_instr !== 32'h1000_0000 + k) begin failures++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, if_instr, 32'h1000_0000 + k); end
         checks++; if (if_pc !== 4 * k || if_pc_plus4 !== 4 * k + 4) begin failures++; $display("FAIL stream_pc k=%0d got=%h/%h exp=%h/%h", k, if_pc, if_pc_plus4, 4 * k, 4 * k + 4); end
         checks++; if (fetch_count !== k) begin failures++; $display("FAIL stream_count k=%0d got=%0d exp=%0d", k, fetch_count, k); end
      end
   endtask

   task automatic test_backpressure();
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (if_valid !== 1'b1 || if_instr !== 32'h1000_0002) begin failures++; $display("FAIL stall_instr cyc=%0d got=%0b/%h exp=1/10000002", i, if_valid, if_instr); end
         checks++; if (imem_addr !== 8'd3) begin failures++; $display("FAIL stall_addr cyc=%0d got=%h exp=03", i, imem_addr); end
         checks++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL stall_count cyc=%0d got=%0d exp=2", i, fetch_count); end
      end
      id_ready = 1'b1;
      @(negedge clk);
      checks++; if (if_instr !== 32'h1000_0003 || if_pc !== 32'h0000_000C) begin failures++; $display("FAIL stall_release got=%h@%h exp=10000003@0000000c", if_instr, if_pc); end
      checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL release_count got=%0d exp=3", fetch_count); end
   endtask

   task automatic test_redirect_stall();
      id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
      @(negedge clk);
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0b exp=0", if_valid); end
      checks++; if (imem_addr !== 8'h10) begin failures++; $display("FAIL redir_addr got=%h exp=10", imem_addr); end
      checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL redir_count got=%0d exp=3", fetch_count); end
      redirect_valid = 1'b0; id_ready = 1'b1;
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_instr !== 32'h1000_0010 || if_pc !== 32'h0000_0040) begin failures++; $display("FAIL redir_target got=%0b/%h@%h exp=1/10000010@00000040", if_valid, if_instr, if_pc); end
   endtask

   task automatic test_wrap_alias();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_03FC;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (if_valid !== 1'b0 || fetch_count !== 32'd4) begin failures++; $display("FAIL wrap_redir got=%0b/%0d exp=0/4", if_valid, fetch_count); end
      checks++; if (imem_addr !== 8'hFF) begin failures++; $display("FAIL wrap_addr got=%h exp=ff", imem_addr); end
      @(negedge clk);
      checks++; if (if_instr !== 32'h1000_00FF || if_pc !== 32'h0000_03FC || if_pc_plus4 !== 32'h0000_0400) begin failures++; $display("FAIL wrap_last got=%h@%h/%h exp=100000ff@000003fc/00000400", if_instr, if_pc, if_pc_plus4); end
      checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL alias_addr got=%h exp=00", imem_addr); end
      @(negedge clk);
      checks++; if (if_instr !== 32'h1000_0000 || if_pc !== 32'h0000_0400 || if_pc_plus4 !== 32'h0000_0404) begin failures++; $display("FAIL alias_word got=%h@%h/%h exp=10000000@00000400/00000404", if_instr, if_pc, if_pc_plus4); end
      checks++; if (fetch_count !== 32'd5) begin failures++; $display("FAIL alias_count got=%0d exp=5", fetch_count); end
   endtask

   task automatic test_misaligned();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
      @(negedge clk);
      checks++; if (fetch_fault !== 1'b1 || if_valid !== 1'b0) begin failures++; $display("FAIL fault_entry got=%0b/%0b exp=1/0", fetch_fault, if_valid); end
      checks++; if (fetch_count !== 32'd6 || imem_addr !== 8'h01) begin failures++; $display("FAIL fault_entry_state got=%0d/%h exp=6/01", fetch_count, imem_addr); end
      for (int i = 0; i < 10; i++) begin
         redirect_valid = i[0]; redirect_pc = 32'h0000_0080; id_ready = 1'b1;
         @(negedge clk);
         checks++; if (fetch_fault !== 1'b1 || if_valid !== 1'b0 || fetch_count !== 32'd6) begin failures++; $display("FAIL fault_hold cyc=%0d got=%0b/%0b/%0d exp=1/0/6", i, fetch_fault, if_valid, fetch_count); end
         checks++; if (imem_addr !== 8'h01 || if_pc !== 32'h0000_0400) begin failures++; $display("FAIL fault_pc cyc=%0d got=%h/%h exp=01/00000400", i, imem_addr, if_pc); end
      end
      redirect_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (fetch_fault !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 8'h00) begin failures++; $display("FAIL fault_clear got=%0b/%0d/%h exp=0/0/00", fetch_fault, fetch_count, imem_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL restart_boot got=%0b exp=0", if_valid); end
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_instr !== 32'h1000_0000 || if_pc !== 32'd0) begin failures++; $display("FAIL restart_first got=%0b/%h@%h exp=1/10000000@00000000", if_valid, if_instr, if_pc); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      checks++; if (if_instr !== 32'h1000_0001 || fetch_count !== 32'd1) begin failures++; $display("FAIL pre_async got=%h/%0d exp=10000001/1", if_instr, fetch_count); end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0000_0013) begin failures++; $display("FAIL async_ifid got=%0b/%h exp=0/00000013", if_valid, if_instr); end
      checks++; if (if_pc !== 32'd0 || if_pc_plus4 !== 32'd0 || imem_addr !== 8'h00) begin failures++; $display("FAIL async_pc got=%h/%h/%h exp=0/0/00", if_pc, if_pc_plus4, imem_addr); end
      checks++; if (fetch_fault !== 1'b0 || fetch_count !== 32'd0) begin failures++; $display("FAIL async_flags got=%0b/%0d exp=0/0", fetch_fault, fetch_count); end
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_stall();
      test_wrap_alias();
      test_misaligned();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the 256-word combinational instruction ROM. It owns the program counter, drives the ROM word address, captures the returned instruction into an IF/ID pipeline register, and hands it to decode over a valid/ready handshake. It also handles control-flow redirects with flush, decode backpressure, misaligned-target faulting and a fetch counter.

## Interface
- XLEN, 32, program counter and data width.
- ADDR_WIDTH, 8, ROM word-address width (2**ADDR_WIDTH instructions).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_WIDTH  ROM word address; always pc[ADDR_WIDTH+1:2].
- imem_rd  in  32  ROM read data, combinationally valid for imem_addr in the same cycle.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse from execute.
- redirect_pc  in  XLEN  redirect target byte address.
- id_ready  in  1  decode can accept the current IF/ID contents.
- if_valid  out  1  IF/ID register holds a live instruction.
- if_instr  out  32  captured instruction.
- if_pc  out  XLEN  byte address of if_instr.
- if_pc_plus4  out  XLEN  if_pc + 4, modulo 2**XLEN.
- fetch_fault  out  1  sticky flag: misaligned redirect seen.
- fetch_count  out  32  number of completed decode handshakes, wraps.

## Operation
- FSM states: BOOT, RUN, FAULT.
  - BOOT: entered on reset. Holds pc, keeps if_valid = 0, and moves to RUN on the next clock.
  - RUN: normal fetching.
  - FAULT: absorbing until rst_n asserts.
- Handshake: a transfer occurs on a cycle with if_valid && id_ready. On each transfer, fetch_count increments by 1 (wraps at 2**32).
- load = !if_valid || id_ready.
- RUN priority, highest first:
  1. redirect_valid with redirect_pc[1:0] != 0:
     - Next state FAULT; if_valid <= 0; fetch_fault <= 1; pc unchanged.
     - The current IF/ID contents are discarded even if a transfer occurs this cycle. fetch_count still counts that transfer.
  2. redirect_valid, aligned target:
     - pc <= redirect_pc; if_valid <= 0 (flush).
     - Overrides stall: applies even when id_ready = 0.
     - The word at the old pc is not captured.
  3. load:
     - if_instr <= imem_rd; if_pc <= pc; if_pc_plus4 <= pc + 4; if_valid <= 1.
     - pc <= pc + 4.
  4. Otherwise (stall): pc and all IF/ID outputs hold.
- FAULT:
  - pc, IF/ID and fetch_fault hold.
  - if_valid = 0.
  - redirect_valid and id_ready are ignored; fetch_count is frozen.
- Address arithmetic:
  - pc + 4 wraps modulo 2**XLEN.
  - imem_addr uses only pc[ADDR_WIDTH+1:2], so pc values of 4*2**ADDR_WIDTH and above alias onto the ROM (e.g. pc 0x400 fetches word 0 when ADDR_WIDTH = 8).
  - pc[1:0] is always 0.
- redirect_pc bits above ADDR_WIDTH+1 are kept in pc and in if_pc; they are not truncated.

## Timing
- Reset values (asynchronous, held while rst_n = 0):
  - state BOOT, pc = RESET_PC.
  - if_valid = 0, if_instr = 32'h0000_0013 (NOP), if_pc = 0, if_pc_plus4 = 0.
  - fetch_fault = 0, fetch_count = 0.
  - imem_addr = RESET_PC[ADDR_WIDTH+1:2].
- Startup: cycle 0 after rst_n rises is BOOT. The first capture happens at the end of cycle 1. if_valid = 1 with if_pc = RESET_PC from cycle 2.
- Fetch latency: the instruction at pc P appears on if_instr exactly one cycle after imem_addr = P[ADDR_WIDTH+1:2].
- Throughput: with id_ready held high, one instruction per cycle.
- Redirect penalty: redirect sampled in cycle N; pc = target in N+1; if_valid = 0 in N+1; target instruction valid in N+2.
- A stall of any length loses and duplicates nothing: if_instr is stable while if_valid && !id_ready.
- rst_n asserted mid-operation forces all reset values immediately, including from FAULT.
- All outputs are registered except imem_addr, which is pc-derived with no other logic.

## Test plan
- Reset/boot: ROM word k = 32'h1000_0000+k, id_ready = 1, release rst_n.
  - if_valid = 0 for 2 cycles.
  - Then if_instr = 0x1000_0000, 0x1000_0001, 0x1000_0002 on consecutive cycles, with if_pc = 0, 4, 8 and if_pc_plus4 = 4, 8, 12.
  - fetch_count = 3 after the third transfer.
- Backpressure: id_ready = 0 for 3 cycles while if_pc = 0x8.
  - if_instr = 0x1000_0002 held; imem_addr = 3 held; fetch_count unchanged.
  - On release, the next instruction is 0x1000_0003 at pc 0xC, with no skip and no duplicate.
- Redirect during stall: id_ready = 0, redirect_valid = 1, redirect_pc = 0x40.
  - Next cycle: if_valid = 0, imem_addr = 0x10.
  - Following cycle: if_instr = 0x1000_0010, if_pc = 0x40.
- Wrap/alias: redirect_pc = 0x3FC.
  - Fetches word 255, then pc = 0x400 fetches word 0 (if_instr = 0x1000_0000, if_pc = 0x400).
- Misaligned redirect: redirect_pc = 0x42.
  - Next cycle: fetch_fault = 1, if_valid = 0.
  - fetch_count frozen and later redirects ignored for 10 cycles.
  - rst_n pulse clears fetch_fault and restarts from RESET_PC.
- Async reset mid-stream: assert rst_n low between clock edges.
  - All outputs take their reset values immediately, without waiting for a clock edge.
